// File: rtl/dram_sipo_rx.sv
// Receive-side deserializer: framed LSB-first serial bits into WIDTH-bit words,
// handed downstream through one valid/ready holding register with sticky error flags.
module dram_sipo_rx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_b,
  input  logic             bit_valid,
  input  logic             frame_start,
  input  logic             serial_in,
  input  logic             clr_err,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             busy,
  output logic             overflow,
  output logic             frame_err
);
  // state | meaning
  // IDLE  | waiting for frame_start with bit_valid
  // RECV  | collecting the remaining bits of a word
  localparam int CW = $clog2(WIDTH) + 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RECV = 1'b1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [0:0]       state;
  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] word;
  logic             start;
  logic             restart;
  logic             shift;
  logic             complete;
  logic             xfer;
  logic             take;

  assign start    = bit_valid & frame_start;
  assign restart  = start & (state == RECV);
  assign shift    = bit_valid & ~frame_start & (state == RECV);
  assign complete = shift & (cnt == LAST);
  assign word     = {serial_in, sh[WIDTH-1:1]};
  assign xfer     = data_valid & data_ready;
  // A held word being consumed this same cycle frees the register for the new one.
  assign take     = complete & (~data_valid | data_ready);
  assign busy     = (state == RECV);

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state <= IDLE;
      cnt   <= '0;
      sh    <= '0;
    end else if (start) begin
      // Stale partial bits are shifted out before the word can complete.
      state <= RECV;
      cnt   <= CW'(1);
      sh    <= word;
    end else if (shift) begin
      sh <= word;
      if (complete) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      if (take) begin
        data_out   <= word;
        data_valid <= 1'b1;
      end else if (xfer) begin
        data_valid <= 1'b0;
      end
      overflow  <= (complete & ~take) | (overflow & ~clr_err);
      frame_err <= restart | (frame_err & ~clr_err);
    end
  end
endmodule

// File: tb/tb_dram_sipo_rx.sv
// Bench for dram_sipo_rx: table-driven frames plus corner-case sequences,
// with a transfer scoreboard checking every accepted word in order.
module tb_dram_sipo_rx;
  logic       clk = 1'b0;
  logic       rst_b;
  logic       bit_valid;
  logic       frame_start;
  logic       serial_in;
  logic       clr_err;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       busy;
  logic       overflow;
  logic       frame_err;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  logic [7:0] mon_exp;

  typedef struct {
    logic [7:0] word;
    logic [7:0] gap_mask;
    int         gap_len;
    int         exp_lat;
  } vec_t;
  vec_t vecs[5];

  dram_sipo_rx #(.WIDTH(8)) dut (
    .clk(clk), .rst_b(rst_b), .bit_valid(bit_valid), .frame_start(frame_start),
    .serial_in(serial_in), .clr_err(clr_err), .data_out(data_out),
    .data_valid(data_valid), .data_ready(data_ready), .busy(busy),
    .overflow(overflow), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Transfers happen at the next rising edge whenever valid and ready are both high.
  always @(negedge clk) begin
    if (rst_b && data_valid && data_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL xfer_unexpected: data_out=%0h, expected no transfer", data_out);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("xfer_data", {24'h0, data_out}, {24'h0, mon_exp});
      end
    end
  end

  task automatic send_word(input logic [7:0] w, input int nbits, input logic [7:0] gmask,
                           input int glen, input bit push, input bit ready_last,
                           output int lat, output bit busy_ok);
    int cyc;
    bit dv_prev;
    cyc = 0;
    lat = -1;
    busy_ok = 1'b1;
    dv_prev = data_valid;
    if (push) exp_q.push_back(w);
    for (int i = 0; i < nbits; i++) begin
      bit_valid   = 1'b1;
      frame_start = (i == 0);
      serial_in   = w[i];
      if (ready_last && i == nbits - 1) data_ready = 1'b1;
      tick();
      cyc++;
      if (!dv_prev && data_valid && lat < 0) lat = cyc;
      if (busy !== ((i == nbits - 1 && nbits == 8) ? 1'b0 : 1'b1)) busy_ok = 1'b0;
      bit_valid   = 1'b0;
      frame_start = 1'b0;
      if (gmask[i] && i < nbits - 1) begin
        for (int g = 0; g < glen; g++) begin
          tick();
          cyc++;
          if (!dv_prev && data_valid && lat < 0) lat = cyc;
          if (busy !== 1'b1) busy_ok = 1'b0;
        end
      end
    end
  endtask

  initial begin
    int lat;
    bit bok;

    vecs[0] = '{word: 8'hA5, gap_mask: 8'h00, gap_len: 0, exp_lat: 8};
    vecs[1] = '{word: 8'h3C, gap_mask: 8'h12, gap_len: 3, exp_lat: 14};
    vecs[2] = '{word: 8'h00, gap_mask: 8'h00, gap_len: 0, exp_lat: 8};
    vecs[3] = '{word: 8'hFF, gap_mask: 8'h01, gap_len: 1, exp_lat: 9};
    vecs[4] = '{word: 8'h81, gap_mask: 8'h40, gap_len: 2, exp_lat: 10};

    rst_b = 1'b0; bit_valid = 1'b0; frame_start = 1'b0; serial_in = 1'b0;
    clr_err = 1'b0; data_ready = 1'b1;
    tick(); tick();
    chk("rst_data_out", {24'h0, data_out}, 32'h0);
    chk("rst_flags", {27'h0, data_valid, busy, overflow, frame_err, 1'b0}, 32'h0);
    rst_b = 1'b1;
    tick();

    // Stray bits without frame_start must be discarded in IDLE.
    bit_valid = 1'b1; serial_in = 1'b1;
    tick(); tick();
    bit_valid = 1'b0;
    chk("idle_discard_busy", {31'h0, busy}, 32'h0);

    for (int v = 0; v < 5; v++) begin
      send_word(vecs[v].word, 8, vecs[v].gap_mask, vecs[v].gap_len, 1'b1, 1'b0, lat, bok);
      chk($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      chk($sformatf("vec%0d_busy", v), {31'h0, bok}, 32'h1);
      chk($sformatf("vec%0d_data_out", v), {24'h0, data_out}, {24'h0, vecs[v].word});
      tick();
      chk($sformatf("vec%0d_valid_drop", v), {31'h0, data_valid}, 32'h0);
    end
    chk("table_flags", {30'h0, overflow, frame_err}, 32'h0);

    // Back-to-back with backpressure: first word held, the rest dropped.
    data_ready = 1'b0;
    send_word(8'h11, 8, 8'h00, 0, 1'b1, 1'b0, lat, bok);
    send_word(8'h22, 8, 8'h00, 0, 1'b0, 1'b0, lat, bok);
    send_word(8'h33, 8, 8'h00, 0, 1'b0, 1'b0, lat, bok);
    chk("bp_held_word", {24'h0, data_out}, 32'h11);
    chk("bp_overflow", {30'h0, overflow, data_valid}, 32'h3);
    data_ready = 1'b1;
    tick();
    chk("bp_valid_after_xfer", {31'h0, data_valid}, 32'h0);
    tick();
    chk("bp_single_xfer", exp_q.size(), 0);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("bp_overflow_clr", {31'h0, overflow}, 32'h0);

    // Consume the held word in the same cycle the next one completes.
    data_ready = 1'b0;
    send_word(8'h55, 8, 8'h00, 0, 1'b1, 1'b0, lat, bok);
    tick();
    send_word(8'h66, 8, 8'h00, 0, 1'b1, 1'b1, lat, bok);
    chk("sim_data_out", {24'h0, data_out}, 32'h66);
    chk("sim_valid_ovf", {30'h0, data_valid, overflow}, 32'h2);
    tick();
    chk("sim_drained", exp_q.size(), 0);

    // Restart mid-frame.
    send_word(8'hFF, 4, 8'h00, 0, 1'b0, 1'b0, lat, bok);
    chk("rs_partial_busy", {31'h0, bok}, 32'h1);
    send_word(8'h0F, 8, 8'h00, 0, 1'b1, 1'b0, lat, bok);
    chk("rs_latency", lat, 8);
    chk("rs_data_out", {24'h0, data_out}, 32'h0F);
    chk("rs_frame_err", {30'h0, frame_err, overflow}, 32'h2);
    tick();
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("rs_frame_err_clr", {31'h0, frame_err}, 32'h0);

    // Reset mid-frame with a held word pending.
    data_ready = 1'b0;
    send_word(8'h77, 8, 8'h00, 0, 1'b0, 1'b0, lat, bok);
    send_word(8'hC3, 3, 8'h00, 0, 1'b0, 1'b0, lat, bok);
    rst_b = 1'b0;
    #1;
    chk("mrst_data_out", {24'h0, data_out}, 32'h0);
    chk("mrst_flags", {28'h0, data_valid, busy, overflow, frame_err}, 32'h0);
    tick();
    rst_b = 1'b1;
    data_ready = 1'b1;
    tick();
    send_word(8'h81, 8, 8'h00, 0, 1'b1, 1'b0, lat, bok);
    chk("mrst_latency", lat, 8);
    chk("mrst_data_out2", {24'h0, data_out}, 32'h81);
    tick();
    tick();
    chk("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
